// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port PRAM / external-bus request arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRAM    = 3'd1,
    PRAM_RD = 3'd2,
    EXT     = 3'd3,
    ERR     = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // addr[15:14] value that selects on-chip PRAM; everything else goes external
  localparam logic [1:0] PRAM_REGION = 2'b00;

  localparam int PORT_CORE = 0;
  localparam int PORT_CRC  = 1;
  localparam int N_PORTS   = 2;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundle of requester, response, PRAM and external-bus signals around mem_req_arbiter.
interface mem_req_arbiter_if;
  // Handshake: a port raises req[i] with its fields and holds them until it sees
  // gnt[i] (one-cycle pulse); exactly one rsp_valid[i] pulse follows each gnt[i],
  // with rsp_err/rsp_rdata meaningful only in that cycle.
  logic [1:0]       req;
  logic [1:0]       req_we;
  logic [1:0][15:0] req_addr;
  logic [1:0][1:0]  req_size;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       gnt;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;

  logic             pram_en;
  logic             pram_we;
  logic [11:0]      pram_addr;
  logic [3:0]       pram_bmask;
  logic [31:0]      pram_wdata;
  logic [31:0]      pram_rdata;

  logic             ext_en;
  logic             ext_we;
  logic [15:0]      ext_addr;
  logic [1:0]       ext_size;
  logic [3:0]       ext_bmask;
  logic [31:0]      ext_wdata;
  logic             ext_rdy;
  logic [31:0]      ext_rdata;

  modport master (
    output req, req_we, req_addr, req_size, req_wdata, pram_rdata, ext_rdy, ext_rdata,
    input  gnt, rsp_valid, rsp_rdata, rsp_err,
    input  pram_en, pram_we, pram_addr, pram_bmask, pram_wdata,
    input  ext_en, ext_we, ext_addr, ext_size, ext_bmask, ext_wdata
  );

  modport slave (
    input  req, req_we, req_addr, req_size, req_wdata, pram_rdata, ext_rdy, ext_rdata,
    output gnt, rsp_valid, rsp_rdata, rsp_err,
    output pram_en, pram_we, pram_addr, pram_bmask, pram_wdata,
    output ext_en, ext_we, ext_addr, ext_size, ext_bmask, ext_wdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Size/alignment legality, byte enables, write-data lane shift and read-data extraction.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic        legal,
  output logic [3:0]  bmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_fmt
);
  logic [31:0] rdata_sh;

  always_comb begin
    legal     = 1'b0;
    bmask     = 4'b0000;
    rdata_fmt = 32'h0;
    wdata_sh  = wdata << {addr_lo, 3'b000};
    rdata_sh  = rdata_raw >> {addr_lo, 3'b000};
    case (size)
      SZ_BYTE: begin
        legal     = 1'b1;
        bmask     = 4'b0001 << addr_lo;
        rdata_fmt = {24'h0, rdata_sh[7:0]};
      end
      SZ_HALF: begin
        legal     = ~addr_lo[0];
        bmask     = addr_lo[1] ? 4'b1100 : 4'b0011;
        rdata_fmt = {16'h0, rdata_sh[15:0]};
      end
      SZ_WORD: begin
        legal     = (addr_lo == 2'b00);
        bmask     = 4'b1111;
        rdata_fmt = rdata_sh;
      end
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of PRAM and the external bus.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int EXT_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  mem_req_arbiter_if.slave   bus,
  output state_t             dbg_state
);
  localparam int CW = $clog2(EXT_TIMEOUT + 1);

  state_t        state, state_nx;
  logic          ptr;
  logic          w;
  logic          l_we;
  logic [15:0]   l_addr;
  logic [1:0]    l_size;
  logic [31:0]   l_wdata;
  logic [CW-1:0] cnt;

  logic          any_req, win;
  logic [1:0]    cur_addr_lo, cur_size;
  logic [31:0]   rdata_raw;
  logic          legal;
  logic [3:0]    bmask;
  logic [31:0]   wdata_sh, rdata_fmt;
  logic          ext_tmo;

  assign any_req = |bus.req;
  assign win     = (&bus.req) ? ptr : bus.req[1];
  assign ext_tmo = (state == EXT) && !bus.ext_rdy && (cnt == CW'(EXT_TIMEOUT - 1));
  assign dbg_state = state;

  // The aligner sees the incoming winner in IDLE (for the legality decision) and
  // the latched request for the rest of the access.
  assign cur_addr_lo = (state == IDLE) ? bus.req_addr[win][1:0] : l_addr[1:0];
  assign cur_size    = (state == IDLE) ? bus.req_size[win] : l_size;
  assign rdata_raw   = (state == PRAM_RD) ? bus.pram_rdata : bus.ext_rdata;

  mem_lane_align u_align (
    .addr_lo   (cur_addr_lo),
    .size      (cur_size),
    .wdata     (l_wdata),
    .rdata_raw (rdata_raw),
    .legal     (legal),
    .bmask     (bmask),
    .wdata_sh  (wdata_sh),
    .rdata_fmt (rdata_fmt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (!legal)                                        state_nx = ERR;
          else if (bus.req_addr[win][15:14] == PRAM_REGION)  state_nx = PRAM;
          else                                               state_nx = EXT;
        end
      end
      PRAM:    state_nx = PRAM_RD;
      PRAM_RD: state_nx = IDLE;
      EXT:     if (bus.ext_rdy || ext_tmo) state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Downstream fields are gated by their strobe so idle buses stay at zero.
  always_comb begin
    bus.pram_en    = (state == PRAM);
    bus.pram_we    = bus.pram_en & l_we;
    bus.pram_addr  = bus.pram_en ? l_addr[13:2] : 12'h0;
    bus.pram_bmask = bus.pram_en ? bmask : 4'h0;
    bus.pram_wdata = bus.pram_en ? wdata_sh : 32'h0;
    bus.ext_en     = (state == EXT);
    bus.ext_we     = bus.ext_en & l_we;
    bus.ext_addr   = bus.ext_en ? l_addr : 16'h0;
    bus.ext_size   = bus.ext_en ? l_size : 2'b00;
    bus.ext_bmask  = bus.ext_en ? bmask : 4'h0;
    bus.ext_wdata  = bus.ext_en ? wdata_sh : 32'h0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr           <= 1'b0;
      w             <= 1'b0;
      l_we          <= 1'b0;
      l_addr        <= 16'h0;
      l_size        <= 2'b00;
      l_wdata       <= 32'h0;
      cnt           <= '0;
      bus.gnt       <= 2'b00;
      bus.rsp_valid <= 2'b00;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= 32'h0;
    end else begin
      bus.gnt       <= 2'b00;
      bus.rsp_valid <= 2'b00;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= 32'h0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (any_req) begin
            w            <= win;
            l_we         <= bus.req_we[win];
            l_addr       <= bus.req_addr[win];
            l_size       <= bus.req_size[win];
            l_wdata      <= bus.req_wdata[win];
            bus.gnt[win] <= 1'b1;
            ptr          <= ~win;
          end
        end
        PRAM_RD: begin
          bus.rsp_valid[w] <= 1'b1;
          bus.rsp_rdata    <= l_we ? 32'h0 : rdata_fmt;
        end
        EXT: begin
          if (bus.ext_rdy) begin
            bus.rsp_valid[w] <= 1'b1;
            bus.rsp_rdata    <= l_we ? 32'h0 : rdata_fmt;
          end else if (ext_tmo) begin
            bus.rsp_valid[w] <= 1'b1;
            bus.rsp_err      <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ERR: begin
          bus.rsp_valid[w] <= 1'b1;
          bus.rsp_err      <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
